// File: rtl/score_bcd_counter.sv
// Purpose: game score counter (IDLE/PLAY/OVER) counting pipe passes in packed BCD, with optional high score.
// Latency: one cycle; a pass edge, crash or start sampled at edge k is visible after edge k.
// Backpressure: none; level inputs are sampled every cycle and outputs are always valid.
//
// Ports:
//   clk, reset         - clock; synchronous active-high reset clearing all state (incl. high score)
//   start              - begins a new game from IDLE or OVER
//   pass               - level from pipe logic; each 0->1 transition in PLAY scores one point
//   crash              - level from collision logic; ends the game (wins over start and pass)
//   show_hi            - selects the high score onto disp_bcd
//   score_bcd          - current score, one 10-bit zero-extended BCD digit per entry (0 = ones)
//   disp_bcd           - score or high score, same format
//   playing, game_over - phase flags
//   new_record         - last finished game set a strictly higher high score
//
// Optional feature: define SCORE_HISCORE_EN to build the high-score register, compare,
// new_record and show_hi mux. Undefined: new_record is 0 and disp_bcd mirrors score_bcd.
module score_bcd_counter #(
    parameter int DIGITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pass,
    input  logic                   crash,
    input  logic                   show_hi,
    output logic [DIGITS-1:0][9:0] score_bcd,
    output logic [DIGITS-1:0][9:0] disp_bcd,
    output logic                   playing,
    output logic                   game_over,
    output logic                   new_record
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    logic [1:0]            state;
    logic [DIGITS-1:0][3:0] score;
    logic [DIGITS-1:0][3:0] score_inc;
    logic                  pass_q;
    logic                  pass_edge;
    logic                  all_nines;
    logic                  carry;
    logic                  game_end;

    assign pass_edge = pass & ~pass_q;
    // The cycle that moves PLAY -> OVER; the high score is evaluated on it.
    assign game_end  = (state == S_PLAY) & crash;

    // Ripple BCD increment: a 9 rolls to 0 and carries; all-nines is detected
    // separately so the score saturates instead of wrapping to zero.
    always_comb begin
        carry     = 1'b1;
        all_nines = 1'b1;
        score_inc = score;
        for (int i = 0; i < DIGITS; i++) begin
            if (score[i] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (score[i] == 4'd9) begin
                    score_inc[i] = 4'd0;
                end else begin
                    score_inc[i] = score[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            score  <= '0;
            pass_q <= 1'b0;
        end else begin
            // Sampled in every state so a pass held across start never counts.
            pass_q <= pass;
            case (state)
                S_IDLE: begin
                    score <= '0;
                    if (start) begin
                        state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (crash) begin
                        state <= S_OVER;
                    end else if (pass_edge && !all_nines) begin
                        score <= score_inc;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        state <= S_PLAY;
                        score <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    score <= '0;
                end
            endcase
        end
    end

    assign playing   = (state == S_PLAY);
    assign game_over = (state == S_OVER);

`ifdef SCORE_HISCORE_EN
    logic [DIGITS-1:0][3:0] hi_score;
    logic                   nr_q;

    // Digits are packed most-significant highest and each stays within 0..9,
    // so a plain unsigned compare of the packed vectors is a decimal compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_score <= '0;
            nr_q     <= 1'b0;
        end else if (game_end) begin
            if (score > hi_score) begin
                hi_score <= score;
                nr_q     <= 1'b1;
            end
        end else if ((state == S_OVER) && start) begin
            nr_q <= 1'b0;
        end
    end

    assign new_record = nr_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_out
        assign score_bcd[g] = {6'b0, score[g]};
        assign disp_bcd[g]  = show_hi ? {6'b0, hi_score[g]} : {6'b0, score[g]};
    end
`else
    logic unused_inputs;
    assign unused_inputs = show_hi | game_end;
    assign new_record    = 1'b0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_out
        assign score_bcd[g] = {6'b0, score[g]};
        assign disp_bcd[g]  = {6'b0, score[g]};
    end
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Purpose: scoreboard bench for score_bcd_counter; directed stimulus pushes expected outputs.
// Latency: expectations are pushed #1 after an edge and checked on the following falling edge.
// Backpressure: none; the monitor drains every queued expectation each falling edge.
module tb_score_bcd_counter;

    localparam int DIGITS = 3;
`ifdef SCORE_HISCORE_EN
    localparam bit HI = 1'b1;
`else
    localparam bit HI = 1'b0;
`endif

    typedef logic [DIGITS-1:0][9:0] bcd_t;

    typedef struct {
        string name;
        int    score;
        int    disp;
        bit    ply;
        bit    go;
        bit    nr;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start, pass, crash, show_hi;
    bcd_t score_bcd, disp_bcd;
    logic playing, game_over, new_record;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    score_bcd_counter #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pass       (pass),
        .crash      (crash),
        .show_hi    (show_hi),
        .score_bcd  (score_bcd),
        .disp_bcd   (disp_bcd),
        .playing    (playing),
        .game_over  (game_over),
        .new_record (new_record)
    );

    always #5 clk = ~clk;

    // Expected packed value: digit i = (v / 10^i) % 10, zero-extended to 10 bits.
    function automatic bcd_t to_bcd(input int v);
        bcd_t r;
        int   x;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i] = 10'(x % 10);
            x    = x / 10;
        end
        return r;
    endfunction

    // Monitor: compares every queued expectation against the DUT outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (score_bcd !== to_bcd(e.score) || disp_bcd !== to_bcd(e.disp) ||
                playing !== e.ply || game_over !== e.go || new_record !== e.nr) begin
                errors++;
                $display("FAIL %s: got score=%h disp=%h ply=%b go=%b nr=%b, want score=%h disp=%h ply=%b go=%b nr=%b",
                         e.name, score_bcd, disp_bcd, playing, game_over, new_record,
                         to_bcd(e.score), to_bcd(e.disp), e.ply, e.go, e.nr);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push expectation and let the monitor see it before inputs move again.
    task automatic expect_out(input string name, input int sc, input int dp,
                              input bit ply, input bit go, input bit nr);
        exp_t e;
        e.name = name; e.score = sc; e.disp = dp; e.ply = ply; e.go = go; e.nr = nr;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // One isolated pass pulse: counted at the first edge, low for the second.
    task automatic pulse_pass;
        pass = 1'b1;
        cyc(1);
        pass = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pass = 1'b0; crash = 1'b0; show_hi = 1'b0;
        cyc(2);
        expect_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc(1);
        expect_out("idle", 0, 0, 0, 0, 0);

        start = 1'b1;
        cyc(1);
        start = 1'b0;
        expect_out("start", 0, 0, 1, 0, 0);

        // 12 isolated passes, including the 9 -> 10 carry.
        for (int i = 1; i <= 12; i++) begin
            pulse_pass();
            expect_out("count12", i, i, 1, 0, 0);
        end

        // Held pass counts once.
        pass = 1'b1;
        cyc(50);
        expect_out("held_pass", 13, 13, 1, 0, 0);
        pass = 1'b0;
        cyc(1);
        expect_out("held_release", 13, 13, 1, 0, 0);

        // Walk up to 999, checking every step (covers 99 -> 100 carry).
        for (int i = 14; i <= 999; i++) begin
            pulse_pass();
            expect_out("preload", i, i, 1, 0, 0);
        end
        pulse_pass();
        expect_out("saturate", 999, 999, 1, 0, 0);

        crash = 1'b1;
        cyc(1);
        crash = 1'b0;
        expect_out("crash999", 999, 999, 0, 1, HI);

        // Reset loses the high score; 7 must then be a new record.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        expect_out("reset_again", 0, 0, 0, 0, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int i = 1; i <= 7; i++) pulse_pass();
        expect_out("score7", 7, 7, 1, 0, 0);

        // Crash with a simultaneous pass edge: edge is lost.
        pass = 1'b1; crash = 1'b1;
        cyc(1);
        pass = 1'b0; crash = 1'b0;
        expect_out("crash7", 7, 7, 0, 1, HI);
        show_hi = 1'b1;
        expect_out("show_hi7", 7, 7, 0, 1, HI);

        start = 1'b1;
        cyc(1);
        start = 1'b0;
        expect_out("restart_hi", 0, HI ? 7 : 0, 1, 0, 0);
        show_hi = 1'b0;
        for (int i = 1; i <= 5; i++) pulse_pass();
        crash = 1'b1;
        cyc(1);
        crash = 1'b0;
        expect_out("crash5", 5, 5, 0, 1, 0);
        show_hi = 1'b1;
        expect_out("show_hi5", 5, HI ? 7 : 5, 0, 1, 0);
        show_hi = 1'b0;

        // Pass ignored in OVER.
        pulse_pass();
        expect_out("over_pass", 5, 5, 0, 1, 0);

        // Pass held across start must fall and rise again.
        pass = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        expect_out("start_pass_hi", 0, 0, 1, 0, 0);
        cyc(3);
        expect_out("still_held", 0, 0, 1, 0, 0);
        pass = 1'b0;
        cyc(1);
        expect_out("pass_fell", 0, 0, 1, 0, 0);
        pass = 1'b1;
        cyc(1);
        pass = 1'b0;
        expect_out("pass_rose", 1, 1, 1, 0, 0);
        cyc(1);

        // Reset mid-PLAY clears everything, including the high score.
        reset = 1'b1;
        show_hi = 1'b1;
        cyc(1);
        expect_out("reset_midplay", 0, 0, 0, 0, 0);
        reset = 1'b0;
        show_hi = 1'b0;

        cyc(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
